mtpsa_digest_splitter: RTL and testbench
========================================

Name: mtpsa_digest_splitter

Overview:
- Sits directly downstream of the user SDNet wrapper in the MTPSA datapath.
- Consumes its AXIS stream, whose tuser is {digest[255:0], metadata[39:0]}.
- Forwards the packet with 40-bit metadata only. Digests flagged send_dig_to_cpu are pushed into a FIFO and presented on a separate digest stream toward the DMA/CPU path.
- Keeps saturating packet and digest counters.

Parameters:
- C_AXIS_DATA_WIDTH, 256, packet data width
- C_META_WIDTH, 40, metadata width (pkt_len/src/dst/send_dig)
- DIGEST_WIDTH, 256, digest width
- DIG_FIFO_DEPTH, 8, digest FIFO entries; must be a power of 2, at least 2
- CNT_WIDTH, 32, statistics counter width

Ports:
- clk_line  in  1  single clock for all logic
- clk_line_rst  in  1  synchronous, active-high reset
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  packet data in
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables
- s_axis_tuser  in  DIGEST_WIDTH+C_META_WIDTH  {digest, metadata}; sampled on SOP beat only
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of packet
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  packet data out
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  byte enables
- m_axis_tuser  out  C_META_WIDTH  metadata, with bits [39:32] cleared
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  end of packet
- m_dig_tdata  out  DIGEST_WIDTH  digest toward CPU
- m_dig_tvalid  out  1  digest valid
- m_dig_tready  in  1  digest ready
- dig_fifo_count  out  $clog2(DIG_FIFO_DEPTH)+1  current FIFO occupancy
- stat_pkt_cnt  out  CNT_WIDTH  packets forwarded (counted on tlast accepted)
- stat_dig_cnt  out  CNT_WIDTH  digests pushed
- stat_dig_drop_cnt  out  CNT_WIDTH  digests discarded because the FIFO was full

Behaviour:
- Single clock clk_line; synchronous active-high reset clk_line_rst.
- Reset values:
  - m_axis_tvalid=0, m_dig_tvalid=0, s_axis_tready=0 while reset is asserted and 1 from the first cycle after reset.
  - All counters 0, dig_fifo_count=0, sop=1.
- Reset mid-packet: the partial packet held in the skid buffer is discarded, FIFO contents are lost, and sop returns to 1.
- Packet path:
  - 2-entry skid buffer (main and skid registers). Latency is 1 cycle from s-accept to m_axis_tvalid.
  - s_axis_tready is registered, equal to !skid_full; no combinational path from m_axis_tready.
  - Full throughput of 1 beat/cycle when m_axis_tready=1.
  - AXIS rule: once m_axis_tvalid is high, data is held stable until accepted.
- SOP tracking: sop is set by an accepted beat with tlast=1 and cleared by an accepted beat with tlast=0. Single-beat packets are both SOP and EOP.
- Metadata:
  - On an accepted SOP beat, meta = tuser[39:0] with bits [39:32] forced to 0. It is stored and driven on m_axis_tuser for every beat of that packet.
  - Non-SOP tuser is ignored.
- Digest capture: condition is accepted SOP beat AND tuser[32]=1.
  - Push tuser[DIGEST_WIDTH+39:40] if count<DIG_FIFO_DEPTH, OR if a pop occurs in the same cycle. Increment stat_dig_cnt.
  - Otherwise, without the optional feature, drop the digest and increment stat_dig_drop_cnt. The packet is still forwarded.
- FIFO:
  - First-word-fall-through: m_dig_tvalid = (count!=0); m_dig_tdata = head.
  - Pop on m_dig_tvalid & m_dig_tready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Counters saturate at all-ones (no wrap). stat_pkt_cnt increments on s-side accepted tlast.

Optional Feature:
- Macro: MTPSA_DIG_BACKPRESSURE_EN
- Defined:
  - s_axis_tready is additionally deasserted when sop & s_axis_tvalid & s_axis_tuser[32] & FIFO full & no pop this cycle.
  - The packet stalls at SOP until space frees, so no digest is ever dropped; stat_dig_drop_cnt is tied to 0.
  - This combinational gating is the only tvalid/tuser-to-tready path.
- Undefined: drop-and-count behaviour as specified in Behaviour.

Decomposition:
- Package mtpsa_digest_pkg:
  - metadata field offsets: PKT_LEN 15:0, SRC_PORT 23:16, DST_PORT 31:24, SEND_DIG bit 32.
  - width constants: META_W=40, DIGEST_W=256.
- Sub-module mtpsa_dig_fifo: synchronous FWFT FIFO with push/pop/count, parameterised by WIDTH and DEPTH.
- The skid buffer stays inline.

Test Plan:
1. 3-beat packet, tuser[32]=1, digest=256'hA5..A5, meta pkt_len=16'd96 -> m_axis carries 3 beats, 1-cycle latency, m_axis_tuser[39:32]=0; one m_dig beat 256'hA5..A5; stat_pkt_cnt=1, stat_dig_cnt=1.
2. 9 single-beat packets with send_dig=1 and m_dig_tready=0 (DEPTH=8) -> dig_fifo_count=8, stat_dig_drop_cnt=1, all 9 packets forwarded. With MTPSA_DIG_BACKPRESSURE_EN -> 9th packet stalls (s_axis_tready=0) until m_dig_tready pulses for 1 cycle, then it is accepted.
3. FIFO full with push and pop in the same cycle -> count stays 8, no drop, head advances.
4. m_axis_tready toggled 1010... over a 5-beat packet -> no beat lost or duplicated, tlast on beat 5 only, tuser constant across all beats.
5. Non-SOP beat carrying tuser[32]=1 -> no digest pushed.
6. clk_line_rst asserted mid-packet for 1 cycle -> all outputs and counters 0, sop=1; the next packet's first beat is treated as SOP.

Source files
------------

// File: rtl/mtpsa_digest_splitter_pkg.sv
// Shared constants for the MTPSA digest splitter: metadata field offsets and widths.
package mtpsa_digest_pkg;

  localparam int META_W   = 40;
  localparam int DIGEST_W = 256;

  localparam int PKT_LEN_LSB  = 0;
  localparam int PKT_LEN_MSB  = 15;
  localparam int SRC_PORT_LSB = 16;
  localparam int SRC_PORT_MSB = 23;
  localparam int DST_PORT_LSB = 24;
  localparam int DST_PORT_MSB = 31;
  localparam int SEND_DIG_BIT = 32;

  // Field view of the 40-bit metadata word; the top byte is cleared before forwarding.
  typedef struct packed {
    logic [6:0]  rsvd;
    logic        sendDig;
    logic [7:0]  dstPort;
    logic [7:0]  srcPort;
    logic [15:0] pktLen;
  } meta_t;

endpackage

// File: rtl/mtpsa_digest_splitter_if.sv
// AXI-Stream bundle used for the packet input, packet output and digest output streams.
interface mtpsa_digest_splitter_if
  import mtpsa_digest_pkg::*;
#(
  parameter int DATA_W = DIGEST_W,
  parameter int USER_W = META_W
);

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/mtpsa_dig_fifo.sv
// First-word-fall-through FIFO holding digests bound for the CPU path; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module mtpsa_dig_fifo
  import mtpsa_digest_pkg::*;
#(
  parameter int WIDTH = DIGEST_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_valid  = (r_count != '0);
  assign o_full   = (r_count == FULL_CNT);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_doPop  = i_pop & o_valid;
  assign w_doPush = i_push & (~o_full | w_doPop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/mtpsa_digest_splitter.sv
// Strips the digest from the SDNet tuser, forwards packets with 40-bit metadata and queues flagged
// digests for the CPU. Define MTPSA_DIG_BACKPRESSURE_EN to stall SOP beats instead of dropping digests.
module mtpsa_digest_splitter
  import mtpsa_digest_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH = 256,
  parameter int C_META_WIDTH      = META_W,
  parameter int DIGEST_WIDTH      = DIGEST_W,
  parameter int DIG_FIFO_DEPTH    = 8,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                             clk_line,
  input  logic                             clk_line_rst,
  mtpsa_digest_splitter_if.slave           s_axis,
  mtpsa_digest_splitter_if.master          m_axis,
  mtpsa_digest_splitter_if.master          m_dig,
  output logic [$clog2(DIG_FIFO_DEPTH):0]  dig_fifo_count,
  output logic [CNT_WIDTH-1:0]             stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]             stat_dig_cnt,
  output logic [CNT_WIDTH-1:0]             stat_dig_drop_cnt
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

  typedef struct packed {
    logic [C_AXIS_DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]            keep;
    logic [C_META_WIDTH-1:0]      meta;
    logic                         last;
  } beat_t;

  beat_t                   r_main;
  beat_t                   r_skid;
  beat_t                   w_inBeat;
  logic                    r_mainValid;
  logic                    r_skidValid;
  logic                    r_sReady;
  logic                    r_sop;
  logic [C_META_WIDTH-1:0] r_curMeta;
  logic [C_META_WIDTH-1:0] w_inMeta;
  logic [CNT_WIDTH-1:0]    r_pktCnt;
  logic [CNT_WIDTH-1:0]    r_digCnt;

  logic w_sAccept;
  logic w_mAccept;
  logic w_mainValidNext;
  logic w_skidValidNext;
  logic w_loadMainFromSkid;
  logic w_loadMainFromIn;
  logic w_loadSkid;
  logic w_digPushReq;
  logic w_digPushOk;
  logic w_digPop;
  logic w_digFull;
  logic w_digValid;

  always_comb begin
    w_inMeta = s_axis.tuser[C_META_WIDTH-1:0];
    w_inMeta[C_META_WIDTH-1:SEND_DIG_BIT] = '0;
    w_inBeat.data = s_axis.tdata;
    w_inBeat.keep = s_axis.tkeep;
    w_inBeat.meta = r_sop ? w_inMeta : r_curMeta;
    w_inBeat.last = s_axis.tlast;
  end

`ifdef MTPSA_DIG_BACKPRESSURE_EN
  logic w_bpStall;
  // Hold a digest-carrying SOP off only when the FIFO cannot take its digest this very cycle.
  assign w_bpStall        = r_sop & s_axis.tvalid & s_axis.tuser[SEND_DIG_BIT] & w_digFull & ~w_digPop;
  assign s_axis.tready    = r_sReady & ~w_bpStall;
  assign stat_dig_drop_cnt = '0;
`else
  logic                 w_digDrop;
  logic [CNT_WIDTH-1:0] r_dropCnt;
  assign s_axis.tready     = r_sReady;
  assign w_digDrop         = w_digPushReq & ~w_digPushOk;
  assign stat_dig_drop_cnt = r_dropCnt;

  always_ff @(posedge clk_line) begin
    if (clk_line_rst)                 r_dropCnt <= '0;
    else if (w_digDrop && ~&r_dropCnt) r_dropCnt <= r_dropCnt + CNT_WIDTH'(1);
  end
`endif

  assign w_sAccept    = s_axis.tvalid & s_axis.tready;
  assign w_mAccept    = r_mainValid & m_axis.tready;
  assign w_digPop     = w_digValid & m_dig.tready;
  assign w_digPushReq = w_sAccept & r_sop & s_axis.tuser[SEND_DIG_BIT];
  assign w_digPushOk  = w_digPushReq & (~w_digFull | w_digPop);

  // The skid register only fills when main is held; tready is registered so it lags by a cycle.
  always_comb begin
    w_mainValidNext    = r_mainValid;
    w_skidValidNext    = r_skidValid;
    w_loadMainFromSkid = 1'b0;
    w_loadMainFromIn   = 1'b0;
    w_loadSkid         = 1'b0;
    if (!r_mainValid || w_mAccept) begin
      if (r_skidValid) begin
        w_loadMainFromSkid = 1'b1;
        w_mainValidNext    = 1'b1;
        w_skidValidNext    = 1'b0;
      end else begin
        w_loadMainFromIn = w_sAccept;
        w_mainValidNext  = w_sAccept;
      end
    end else if (w_sAccept) begin
      w_loadSkid      = 1'b1;
      w_skidValidNext = 1'b1;
    end
  end

  always_ff @(posedge clk_line) begin
    if (clk_line_rst) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_sReady    <= 1'b0;
      r_sop       <= 1'b1;
      r_curMeta   <= '0;
      r_pktCnt    <= '0;
      r_digCnt    <= '0;
    end else begin
      r_mainValid <= w_mainValidNext;
      r_skidValid <= w_skidValidNext;
      r_sReady    <= ~w_skidValidNext;
      if (w_sAccept) begin
        r_sop     <= s_axis.tlast;
        r_curMeta <= w_inBeat.meta;
      end
      if (w_sAccept && s_axis.tlast && ~&r_pktCnt) r_pktCnt <= r_pktCnt + CNT_WIDTH'(1);
      if (w_digPushOk && ~&r_digCnt)               r_digCnt <= r_digCnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_line) begin
    if (w_loadMainFromSkid)    r_main <= r_skid;
    else if (w_loadMainFromIn) r_main <= w_inBeat;
    if (w_loadSkid)            r_skid <= w_inBeat;
  end

  mtpsa_dig_fifo #(
    .WIDTH (DIGEST_WIDTH),
    .DEPTH (DIG_FIFO_DEPTH)
  ) u_digFifo (
    .clk     (clk_line),
    .rst     (clk_line_rst),
    .i_push  (w_digPushReq),
    .i_data  (s_axis.tuser[DIGEST_WIDTH+C_META_WIDTH-1:C_META_WIDTH]),
    .i_pop   (m_dig.tready),
    .o_data  (m_dig.tdata),
    .o_valid (w_digValid),
    .o_full  (w_digFull),
    .o_count (dig_fifo_count)
  );

  assign m_axis.tdata  = r_main.data;
  assign m_axis.tkeep  = r_main.keep;
  assign m_axis.tuser  = r_main.meta;
  assign m_axis.tlast  = r_main.last;
  assign m_axis.tvalid = r_mainValid;

  assign m_dig.tvalid = w_digValid;
  assign m_dig.tkeep  = '1;
  assign m_dig.tuser  = '0;
  assign m_dig.tlast  = 1'b1;

  assign stat_pkt_cnt = r_pktCnt;
  assign stat_dig_cnt = r_digCnt;

endmodule

// File: tb/tb_mtpsa_digest_splitter.sv
// Bench for mtpsa_digest_splitter: directed and random packets checked against a queue-based model.
// Also covers the MTPSA_DIG_BACKPRESSURE_EN build when that macro is defined.
module tb_mtpsa_digest_splitter;

  localparam int DW    = 256;
  localparam int KW    = DW / 8;
  localparam int MW    = 40;
  localparam int GW    = 256;
  localparam int DEPTH = 8;
  localparam int CW    = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [MW-1:0] meta;
  } beat_t;

  logic clk_line = 1'b0;
  logic clk_line_rst;
  always #5 clk_line = ~clk_line;

  mtpsa_digest_splitter_if #(.DATA_W(DW), .USER_W(GW+MW)) s_axis ();
  mtpsa_digest_splitter_if #(.DATA_W(DW), .USER_W(MW))    m_axis ();
  mtpsa_digest_splitter_if #(.DATA_W(GW), .USER_W(1))     m_dig ();

  logic [$clog2(DEPTH):0] digFifoCount;
  logic [CW-1:0]          statPkt;
  logic [CW-1:0]          statDig;
  logic [CW-1:0]          statDrop;

  mtpsa_digest_splitter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_META_WIDTH      (MW),
    .DIGEST_WIDTH      (GW),
    .DIG_FIFO_DEPTH    (DEPTH),
    .CNT_WIDTH         (CW)
  ) dut (
    .clk_line          (clk_line),
    .clk_line_rst      (clk_line_rst),
    .s_axis            (s_axis),
    .m_axis            (m_axis),
    .m_dig             (m_dig),
    .dig_fifo_count    (digFifoCount),
    .stat_pkt_cnt      (statPkt),
    .stat_dig_cnt      (statDig),
    .stat_dig_drop_cnt (statDrop)
  );

  // Reference model: what has been accepted but not yet delivered, plus counters.
  beat_t         expBeats[$];
  logic [GW-1:0] expDigs[$];
  int            mPkt, mDig, mDrop;
  bit            mSop, mPrimed, lastAcc, randMode;
  logic [MW-1:0] mMeta;
  int            checks, errors;

  task automatic checkOutput(input string tag, input logic [295:0] observed, input logic [295:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock with the inputs currently driven; checks outputs and advances the model.
  task automatic applyStimulus();
    beat_t b;
    logic  expReady;
    bit    mAcc, dPop;
    #1;
    lastAcc = 1'b0;
    if (!clk_line_rst) begin
      expReady = mPrimed && (expBeats.size() < 2);
`ifdef MTPSA_DIG_BACKPRESSURE_EN
      if (mSop && s_axis.tvalid && s_axis.tuser[32] && expDigs.size() == DEPTH && !m_dig.tready)
        expReady = 1'b0;
`endif
      checkOutput("s_tready", s_axis.tready, expReady);
      checkOutput("m_tvalid", m_axis.tvalid, expBeats.size() != 0);
      checkOutput("dig_tvalid", m_dig.tvalid, expDigs.size() != 0);
      checkOutput("dig_count", digFifoCount, expDigs.size());
      checkOutput("pkt_cnt", statPkt, mPkt);
      checkOutput("dig_cnt", statDig, mDig);
      checkOutput("drop_cnt", statDrop, mDrop);
      mAcc = m_axis.tready && expBeats.size() != 0;
      dPop = m_dig.tready && expDigs.size() != 0;
      if (mAcc) begin
        b = expBeats.pop_front();
        checkOutput("m_tdata", m_axis.tdata, b.data);
        checkOutput("m_tkeep", m_axis.tkeep, b.keep);
        checkOutput("m_tlast", m_axis.tlast, b.last);
        checkOutput("m_tuser", m_axis.tuser, b.meta);
      end
      if (dPop) checkOutput("dig_tdata", m_dig.tdata, expDigs.pop_front());
      if (s_axis.tvalid && expReady) begin
        lastAcc = 1'b1;
        if (mSop) begin
          mMeta = s_axis.tuser[MW-1:0] & 40'h00_FFFF_FFFF;
          if (s_axis.tuser[32]) begin
            if (expDigs.size() < DEPTH) begin
              expDigs.push_back(s_axis.tuser[GW+MW-1:MW]);
              mDig++;
            end else mDrop++;
          end
        end
        b.data = s_axis.tdata; b.keep = s_axis.tkeep; b.last = s_axis.tlast; b.meta = mMeta;
        expBeats.push_back(b);
        if (s_axis.tlast) mPkt++;
        mSop = s_axis.tlast;
      end
    end
    @(posedge clk_line);
    if (clk_line_rst) begin
      expBeats.delete(); expDigs.delete();
      mPkt = 0; mDig = 0; mDrop = 0; mSop = 1'b1; mPrimed = 1'b0;
    end else mPrimed = 1'b1;
    @(negedge clk_line);
  endtask

  task automatic sendBeat(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                          input logic [GW+MW-1:0] user, input logic last);
    s_axis.tdata = data; s_axis.tkeep = keep; s_axis.tuser = user; s_axis.tlast = last;
    s_axis.tvalid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (randMode) begin
        m_axis.tready = ($urandom_range(0, 3) != 0);
        m_dig.tready  = $urandom_range(0, 1);
      end
      applyStimulus();
      if (lastAcc) break;
    end
    if (!lastAcc) checkOutput("send_timeout", 0, 1);
    s_axis.tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  function automatic logic [GW+MW-1:0] mkUser(input logic [GW-1:0] dig, input logic [7:0] top,
                                                input logic [15:0] len);
    return {dig, top, 8'h03, 8'h05, len};
  endfunction

  initial begin
    int sent;
    checks = 0; errors = 0; mSop = 1'b1; mPrimed = 1'b0; randMode = 1'b0; mMeta = '0;
    mPkt = 0; mDig = 0; mDrop = 0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tuser = '0; s_axis.tlast = 1'b0;
    m_axis.tready = 1'b1; m_dig.tready = 1'b1;
    clk_line_rst = 1'b1;
    @(negedge clk_line);
    idle(2);
    checkOutput("rst_s_tready", s_axis.tready, 0);
    checkOutput("rst_m_tvalid", m_axis.tvalid, 0);
    checkOutput("rst_dig_tvalid", m_dig.tvalid, 0);
    checkOutput("rst_dig_count", digFifoCount, 0);
    checkOutput("rst_pkt_cnt", statPkt, 0);
    clk_line_rst = 1'b0;
    idle(2);

    $display("[TB] 3-beat packet with digest");
    sendBeat(rand256(), '1, mkUser({32{8'hA5}}, 8'hE1, 16'd96), 1'b0);
    sendBeat(rand256(), '1, rand256(), 1'b0);
    sendBeat(rand256(), 32'h0000_FFFF, rand256(), 1'b1);
    idle(4);
    checkOutput("t1_pkt_cnt", statPkt, 1);
    checkOutput("t1_dig_cnt", statDig, 1);

    $display("[TB] fill digest FIFO");
    m_dig.tready = 1'b0;
    for (int p = 0; p < 8; p++) sendBeat(rand256(), '1, mkUser(rand256(), 8'h01, 16'd64), 1'b1);
`ifdef MTPSA_DIG_BACKPRESSURE_EN
    s_axis.tdata = rand256(); s_axis.tkeep = '1; s_axis.tlast = 1'b1;
    s_axis.tuser = mkUser(rand256(), 8'h01, 16'd64); s_axis.tvalid = 1'b1;
    idle(3);
    checkOutput("t2_stalled", s_axis.tready, 0);
    m_dig.tready = 1'b1;
    applyStimulus();
    checkOutput("t2_accept_on_pop", lastAcc, 1);
    m_dig.tready = 1'b0;
    s_axis.tvalid = 1'b0;
    idle(3);
    checkOutput("t2_drop", statDrop, 0);
`else
    sendBeat(rand256(), '1, mkUser(rand256(), 8'h01, 16'd64), 1'b1);
    idle(3);
    checkOutput("t2_drop", statDrop, 1);
`endif
    checkOutput("t2_count_full", digFifoCount, 8);

    $display("[TB] push and pop on a full FIFO");
    m_dig.tready = 1'b1;
    sendBeat(rand256(), '1, mkUser(rand256(), 8'h01, 16'd64), 1'b1);
    m_dig.tready = 1'b0;
    checkOutput("t3_count_held", digFifoCount, 8);
    m_dig.tready = 1'b1;
    idle(10);

    $display("[TB] 5-beat packet with toggling m_axis_tready");
    sent = 0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      m_axis.tready = (c % 2 == 0);
      if (!s_axis.tvalid || lastAcc) begin
        s_axis.tdata = rand256(); s_axis.tkeep = '1; s_axis.tlast = (sent == 4);
        s_axis.tuser = (sent == 0) ? mkUser(rand256(), 8'h00, 16'd160) : rand256();
        s_axis.tuser[32] = 1'b1;
      end
      s_axis.tvalid = 1'b1;
      applyStimulus();
      if (lastAcc) sent++;
    end
    s_axis.tvalid = 1'b0;
    checkOutput("t4_beats_sent", sent, 5);
    m_axis.tready = 1'b1;
    idle(4);

    $display("[TB] send_dig only on a non-SOP beat");
    sendBeat(rand256(), '1, mkUser(rand256(), 8'h00, 16'd70), 1'b0);
    sendBeat(rand256(), '1, mkUser(rand256(), 8'h01, 16'd70), 1'b1);
    idle(3);
    checkOutput("t5_no_digest", digFifoCount, 0);

    $display("[TB] random traffic");
    randMode = 1'b1;
    for (int p = 0; p < 25; p++) begin
      int len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++)
        sendBeat(rand256(), KW'($urandom), {rand256(), 8'($urandom), 32'($urandom)}, b == len - 1);
    end
    randMode = 1'b0;
    m_axis.tready = 1'b1; m_dig.tready = 1'b1;
    idle(12);

    $display("[TB] reset mid-packet");
    m_axis.tready = 1'b0; m_dig.tready = 1'b0;
    sendBeat(rand256(), '1, mkUser(rand256(), 8'h01, 16'd50), 1'b0);
    sendBeat(rand256(), '1, rand256(), 1'b0);
    clk_line_rst = 1'b1;
    applyStimulus();
    checkOutput("t6_m_tvalid", m_axis.tvalid, 0);
    checkOutput("t6_dig_tvalid", m_dig.tvalid, 0);
    checkOutput("t6_s_tready", s_axis.tready, 0);
    checkOutput("t6_dig_count", digFifoCount, 0);
    checkOutput("t6_pkt_cnt", statPkt, 0);
    checkOutput("t6_dig_cnt", statDig, 0);
    clk_line_rst = 1'b0;
    m_axis.tready = 1'b1; m_dig.tready = 1'b1;
    applyStimulus();
    sendBeat(rand256(), '1, mkUser({32{8'h5A}}, 8'h81, 16'd33), 1'b1);
    idle(4);
    checkOutput("t6_pkt_after", statPkt, 1);
    checkOutput("t6_dig_after", statDig, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
